downcount_seq_monitor: RTL and testbench
========================================

Name: downcount_seq_monitor

Overview:
- Sits directly downstream of the 4-bit synchronous T-flip-flop down-counter.
- Consumes the counter's q1..q4 together with the counter's enable and reset. Checks every cycle that the count sequence is legal: decrement by 1 when enabled, hold when disabled, load RESET_VAL on reset.
- Flags underflow wraps (0000 -> 1111), counts them, and latches a sticky error with a cause code on any illegal transition.

Parameters:
- WRAP_W, 8, width of the saturating wrap counter.
- RESET_VAL, 4'b0000, value the counter holds after its own reset.

Ports:
- clk  in  1  rising-edge clock, shared with the counter
- reset  in  1  synchronous, active-low reset of this block
- cnt_rst  in  1  the counter's reset input (active-high), sampled alongside q
- en  in  1  the counter's enable, sampled alongside q
- q1  in  1  counter bit 0 (LSB)
- q2  in  1  counter bit 1
- q3  in  1  counter bit 2
- q4  in  1  counter bit 3 (MSB)
- clr_err  in  1  clears error and re-arms the monitor
- wrap_pulse  out  1  one-cycle pulse per detected underflow
- zero_flag  out  1  registered: sampled count == 0000
- wrap_count  out  WRAP_W  number of wraps seen, saturating
- wrap_sat  out  1  wrap_count has reached all-ones
- err  out  1  sticky error
- err_code  out  2  cause of first error: 00 none, 01 hold violation, 10 bad step, 11 bad reset load

Behaviour:
- Sampling:
  - Every posedge samples cur = {q4,q3,q2,q1}, en and cnt_rst.
  - prev_q, prev_en and prev_rst are kept from the previous edge.
- Expected value at edge k+1, derived from edge-k samples:
  - prev_rst=1 -> RESET_VAL (cause 11 on mismatch).
  - else prev_en=1 -> prev_q - 1 mod 16 (cause 10 on mismatch).
  - else prev_q (cause 01 on mismatch).
- FSM states (encoding in package):
  - INIT: entered on reset and on clr_err. Captures prev_* only; performs no checking and no wrap detection. Unconditionally -> TRACK next edge.
  - TRACK: compares cur against expected each edge.
    - Mismatch -> ERROR; err<=1; err_code<=cause.
    - Match with prev_q=0000, cur=1111, prev_en=1, prev_rst=0 -> wrap_pulse<=1 for exactly one cycle; wrap_count<=wrap_count+1 unless saturated.
  - ERROR: err and err_code held; wrap_count frozen; wrap_pulse=0. Stays until clr_err.
- Latency: all outputs are registered. wrap_pulse, err and zero_flag become visible in the cycle after the edge where the offending or wrapping sample was taken.
- wrap_sat is high when wrap_count is all-ones. It stays high until reset; no further increments occur.
- clr_err:
  - In any state -> INIT next edge.
  - Clears err and err_code; wrap_count is retained.
  - If clr_err coincides with a mismatch, clr_err wins and no error is latched.
- Only the first error cause is recorded; later mismatches in ERROR are ignored.
- A counter reset (cnt_rst) is a legal event, not an error, provided the next sample equals RESET_VAL. It produces no wrap even if prev_q was 0000.
- reset=0 at an edge, including mid-operation, takes effect on that edge:
  - state=INIT; wrap_pulse=0, zero_flag=0, wrap_count=0, wrap_sat=0, err=0, err_code=00; prev_* cleared.
  - Reset has priority over clr_err and over all checks.

Decomposition:
- Package downcount_mon_pkg holds:
  - state encodings: INIT=2'b00, TRACK=2'b01, ERROR=2'b10;
  - error codes: ERR_NONE, ERR_HOLD, ERR_STEP, ERR_RST;
  - constant CNT_W=4.
- One sub-module: wrap_event_counter, a WRAP_W-bit saturating counter with inc and active-low synchronous reset, exposing count and sat.
- Expected-value logic and the FSM stay in the top module.

Test Plan:
- Reset, then counter reset to 0000, then en=1 for 18 cycles: sequence 0000,1111,1110,...: exactly one wrap_pulse, one cycle after the 1111 sample; wrap_count=1; err=0 throughout.
- en=1 counting; drop en for 2 cycles at 1001; resume: q holds 1001 twice, then 1000; err=0, no wrap.
- Force q 0110 -> 0100 with en=1: err=1, err_code=10 next cycle, state ERROR. Later transitions change nothing; pulse clr_err -> err=0, INIT, then TRACK.
- en=0 with q changing 0011 -> 0010: err_code=01. Simultaneously assert clr_err on a mismatch edge: err stays 0.
- WRAP_W=2, run 5 full wraps: wrap_count goes 1,2,3,3,3; wrap_sat=1 after the third wrap; wrap_pulse still fires on every wrap.
- Assert reset=0 mid-count at q=0101 with err set: next cycle all outputs zero and state INIT. cnt_rst with the next sample != RESET_VAL: err_code=11.

Source files
------------

// File: rtl/downcount_mon_pkg.sv
// rtl/downcount_mon_pkg.sv - shared types and helpers for the down-counter sequence monitor
package downcount_mon_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    INIT  = 2'b00,
    TRACK = 2'b01,
    ERROR = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_HOLD = 2'b01,
    ERR_STEP = 2'b10,
    ERR_RST  = 2'b11
  } err_code_t;

  // Underflow is the only legal step that lands on all-ones from zero.
  function automatic logic is_wrap(input logic [CNT_W-1:0] pq, input logic [CNT_W-1:0] cq);
    return (pq == '0) && (cq == '1);
  endfunction

endpackage

// File: rtl/wrap_event_counter.sv
// rtl/wrap_event_counter.sv - saturating event counter for detected underflow wraps
module wrap_event_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = &count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/downcount_seq_monitor.sv
// rtl/downcount_seq_monitor.sv - checks a 4-bit down-counter's sequence, counts wraps, latches first error
module downcount_seq_monitor
  import downcount_mon_pkg::*;
#(
  parameter int               WRAP_W    = 8,
  parameter logic [CNT_W-1:0] RESET_VAL = 4'b0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cnt_rst,
  input  logic              en,
  input  logic              q1,
  input  logic              q2,
  input  logic              q3,
  input  logic              q4,
  input  logic              clr_err,
  output logic              wrap_pulse,
  output logic              zero_flag,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              wrap_sat,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t           state, state_nxt;
  err_code_t        cause;
  logic [CNT_W-1:0] cur, prev_q, exp_q;
  logic             prev_en, prev_rst;
  logic             mismatch, wrap_det;
  logic             err_nxt;
  logic [1:0]       code_nxt;

  assign cur      = {q4, q3, q2, q1};
  assign mismatch = (cur != exp_q);

  // Expected sample follows the counter's own priority: reset, then enable, then hold.
  always_comb begin
    exp_q = prev_q;
    cause = ERR_HOLD;
    if (prev_rst) begin
      exp_q = RESET_VAL;
      cause = ERR_RST;
    end else if (prev_en) begin
      exp_q = prev_q - 1'b1;
      cause = ERR_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= INIT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = err;
    code_nxt  = err_code;
    wrap_det  = 1'b0;
    case (state)
      INIT:  state_nxt = TRACK;
      TRACK: begin
        if (mismatch) begin
          state_nxt = ERROR;
          err_nxt   = 1'b1;
          code_nxt  = cause;
        end else if (is_wrap(prev_q, cur) && prev_en && !prev_rst) begin
          wrap_det = 1'b1;
        end
      end
      ERROR:   state_nxt = ERROR;
      default: state_nxt = INIT;
    endcase
    // Re-arming beats any mismatch seen on the same edge.
    if (clr_err) begin
      state_nxt = INIT;
      err_nxt   = 1'b0;
      code_nxt  = ERR_NONE;
      wrap_det  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_q     <= '0;
      prev_en    <= 1'b0;
      prev_rst   <= 1'b0;
      zero_flag  <= 1'b0;
      wrap_pulse <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      prev_q     <= cur;
      prev_en    <= en;
      prev_rst   <= cnt_rst;
      zero_flag  <= (cur == '0);
      wrap_pulse <= wrap_det;
      err        <= err_nxt;
      err_code   <= code_nxt;
    end
  end

  wrap_event_counter #(
    .W(WRAP_W)
  ) u_wrap_cnt (
    .clk    (clk),
    .resetn (reset),
    .inc    (wrap_det),
    .count  (wrap_count),
    .sat    (wrap_sat)
  );

endmodule

// File: tb/tb_downcount_seq_monitor.sv
// tb/tb_downcount_seq_monitor.sv - directed self-checking bench for downcount_seq_monitor
module tb_downcount_seq_monitor;
  import downcount_mon_pkg::*;

  logic       clk = 1'b0;
  logic       reset, cnt_rst, en, q1, q2, q3, q4, clr_err;
  logic       wrap_pulse, zero_flag, wrap_sat, err;
  logic [7:0] wrap_count;
  logic [1:0] err_code;
  logic       s_wrap_pulse, s_zero_flag, s_wrap_sat, s_err;
  logic [1:0] s_wrap_count;
  logic [1:0] s_err_code;

  int tests = 0;
  int fails = 0;
  int pulses;

  always #5 clk = ~clk;

  downcount_seq_monitor dut (
    .clk(clk), .reset(reset), .cnt_rst(cnt_rst), .en(en),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4), .clr_err(clr_err),
    .wrap_pulse(wrap_pulse), .zero_flag(zero_flag), .wrap_count(wrap_count),
    .wrap_sat(wrap_sat), .err(err), .err_code(err_code)
  );

  downcount_seq_monitor #(.WRAP_W(2)) dut_small (
    .clk(clk), .reset(reset), .cnt_rst(cnt_rst), .en(en),
    .q1(q1), .q2(q2), .q3(q3), .q4(q4), .clr_err(clr_err),
    .wrap_pulse(s_wrap_pulse), .zero_flag(s_zero_flag), .wrap_count(s_wrap_count),
    .wrap_sat(s_wrap_sat), .err(s_err), .err_code(s_err_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one sample, let one rising edge take it, then look 1ns later.
  task automatic step(input logic [3:0] v, input logic e, input logic r, input logic c, input logic rn);
    {q4, q3, q2, q1} = v;
    en = e; cnt_rst = r; clr_err = c; reset = rn;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_code"}, err_code, 2'b00);
    chk({tag, "_pulse"}, wrap_pulse, 1'b0);
    chk({tag, "_count"}, wrap_count, 8'd0);
    chk({tag, "_sat"}, wrap_sat, 1'b0);
    chk({tag, "_zero"}, zero_flag, 1'b0);
    chk({tag, "_state"}, dut.state, INIT);
  endtask

  initial begin
    {q4, q3, q2, q1} = 4'b0000;
    en = 1'b0; cnt_rst = 1'b0; clr_err = 1'b0; reset = 1'b0;
    #2;

    // Reset state
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_zero_outputs("rst");

    // Counter reset, then count down through an underflow
    step(4'b0101, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("init_to_track", dut.state, TRACK);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rstload_err", err, 1'b0);
    chk("rstload_nowrap", wrap_pulse, 1'b0);
    chk("rstload_zero", zero_flag, 1'b1);
    pulses = 0;
    for (int i = 1; i <= 16; i++) begin
      step(4'(16 - i), 1'b1, 1'b0, 1'b0, 1'b1);
      if (wrap_pulse) pulses++;
      if (i == 1) chk("wrap_pulse_after_1111", wrap_pulse, 1'b1);
      if (i == 2) chk("wrap_pulse_one_cycle", wrap_pulse, 1'b0);
      chk("count_err", err, 1'b0);
    end
    chk("wrap_pulses", pulses, 1);
    chk("wrap_count_1", wrap_count, 8'd1);
    chk("zero_after_loop", zero_flag, 1'b1);

    // Enable drop: counter holds 1001, then resumes
    step(4'b1011, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("clr_to_init", dut.state, INIT);
    step(4'b1010, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'b1001, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'b1001, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'b1001, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("hold_err", err, 1'b0);
    step(4'b1000, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'b0111, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("resume_err", err, 1'b0);
    chk("resume_nowrap", wrap_count, 8'd1);

    // Bad step 0110 -> 0100
    step(4'b0110, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'b0100, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("step_err", err, 1'b1);
    chk("step_code", err_code, 2'b10);
    chk("step_state", dut.state, ERROR);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("error_no_pulse", wrap_pulse, 1'b0);
    step(4'b0011, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("error_code_kept", err_code, 2'b10);
    chk("error_count_frozen", wrap_count, 8'd1);
    step(4'b0011, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_err", err, 1'b0);
    chk("clr_code", err_code, 2'b00);
    chk("clr_state", dut.state, INIT);
    chk("clr_keeps_count", wrap_count, 8'd1);
    step(4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rearm_state", dut.state, TRACK);

    // Hold violation, then clr_err coinciding with a mismatch
    step(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("hold_code", err_code, 2'b01);
    chk("hold_viol_err", err, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b1, 1'b1);
    step(4'b0010, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'b0101, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr_wins_err", err, 1'b0);
    chk("clr_wins_state", dut.state, INIT);
    step(4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);
    step(4'b0101, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_wins_later", err, 1'b0);

    // Reset mid-operation with an error latched
    step(4'b0111, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("pre_reset_err", err, 1'b1);
    step(4'b0101, 1'b1, 1'b0, 1'b1, 1'b0);
    chk_zero_outputs("midrst");

    // Counter reset followed by a wrong load value
    step(4'b0101, 1'b1, 1'b0, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_ok_err", err, 1'b0);
    step(4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("badload_err", err, 1'b1);
    chk("badload_code", err_code, 2'b11);

    // Counter reset from 0000 is legal and produces no wrap
    step(4'b0000, 1'b1, 1'b0, 1'b1, 1'b1);
    step(4'b0000, 1'b1, 1'b1, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_from_zero_err", err, 1'b0);
    chk("rst_from_zero_nowrap", wrap_pulse, 1'b0);

    // Saturation with WRAP_W=2 across five wraps
    step(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sat_rst_count", s_wrap_count, 2'd0);
    step(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int w = 1; w <= 5; w++) begin
      for (int i = 1; i <= 16; i++) begin
        step(4'(16 - i), 1'b1, 1'b0, 1'b0, 1'b1);
        if (i == 1) begin
          chk($sformatf("sat_pulse_%0d", w), s_wrap_pulse, 1'b1);
          chk($sformatf("sat_count_%0d", w), s_wrap_count, (w >= 3) ? 2'd3 : 2'(w));
          chk($sformatf("sat_flag_%0d", w), s_wrap_sat, (w >= 3) ? 1'b1 : 1'b0);
          chk($sformatf("wide_count_%0d", w), wrap_count, 8'(w));
        end
      end
    end
    chk("sat_err", s_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
